pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, 32, address width in bits (>= 8).
REQ-002 Parameter RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, 32'h0000_0080, PC value loaded on trap or misaligned redirect.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries (power of two, >= 2).
REQ-005 Clock is clk; reset is reset, synchronous, active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 stall  input  1  hold PC and RAS unchanged.
REQ-009 trap  input  1  redirect to TRAP_VECTOR; overrides stall.
REQ-010 ret  input  1  redirect to popped RAS entry.
REQ-011 jump  input  1  redirect to jump_target.
REQ-012 call  input  1  qualifies jump: push pc_out+4 onto RAS.
REQ-013 jump_target  input  WIDTH  jump destination.
REQ-014 branch_taken  input  1  redirect to branch_target.
REQ-015 branch_target  input  WIDTH  branch destination.
REQ-016 pc_out  output  WIDTH  current PC (registered).
REQ-017 pc_plus4  output  WIDTH  pc_out+4, combinational, modulo 2^WIDTH.
REQ-018 redirect  output  1  registered pulse: PC last updated non-sequentially.
REQ-019 misaligned  output  1  registered pulse: selected target had bits[1:0] != 0.
REQ-020 ras_empty / ras_full  output  1 each  RAS occupancy flags (registered state).

Function
REQ-021 Next-PC priority SHALL be: reset > trap > stall > ret > jump > branch_taken > sequential (pc_out+4).
REQ-022 All updates SHALL occur on rising clk; pc_out SHALL change exactly one cycle after the qualifying inputs are sampled.
REQ-023 Sequential increment SHALL wrap modulo 2^WIDTH (all-ones-minus-3 +4 -> 0) with no flag.
REQ-024 When stall=1 and trap=0, pc_out, RAS contents, pointer, count, redirect and misaligned SHALL hold/deassert (redirect=0, misaligned=0).
REQ-025 If the selected ret/jump/branch target has bits[1:0] != 0, pc_out SHALL load TRAP_VECTOR, misaligned=1, redirect=1, and no RAS push/pop SHALL occur.
REQ-026 jump with call=1 SHALL push pc_out+4; call with jump=0 SHALL be ignored.
REQ-027 ret with RAS non-empty SHALL pop the top entry into pc_out; ret with RAS empty SHALL take the sequential path, no redirect.
REQ-028 ret and jump together: ret wins; jump/call ignored (no push).
REQ-029 RAS SHALL be circular: push when full overwrites the oldest entry, count stays RAS_DEPTH.
REQ-030 ras_empty SHALL be 1 iff count=0; ras_full SHALL be 1 iff count=RAS_DEPTH.
REQ-031 trap SHALL not modify RAS contents or count.

Reset
REQ-032 On reset: pc_out=RESET_VECTOR, RAS count=0, pointer=0, ras_empty=1, ras_full=0, redirect=0, misaligned=0.
REQ-033 Reset asserted mid-stall or concurrent with trap/ret/jump SHALL take precedence; RAS entry storage need not be cleared.

Structure
REQ-034 Shared package pc_unit_pkg SHALL hold the next-PC select enum (SEL_RESET, SEL_TRAP, SEL_HOLD, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_SEQ) and the PC step constant (4).
REQ-035 RAS SHALL be a sub-module pc_ras (push, pop, push_data, top, empty, full; parameter DEPTH, WIDTH).

Verification
REQ-036 Reset then 3 free cycles -> pc_out 0x0, 0x4, 0x8, 0xC; redirect=0 throughout.
REQ-037 At pc=0x10 jump+call to 0x100, then ret -> pc 0x100 then 0x14; ras_empty 0->1 after ret; redirect pulses both cycles.
REQ-038 Five jump+call at pcs 0x0,0x100,0x200,0x300,0x400 (DEPTH 4) then 5 rets -> pops 0x404,0x304,0x204,0x104, then sequential; ras_full=1 after 4th push.
REQ-039 branch_taken to 0x202 -> pc_out=0x80, misaligned=1 one cycle, RAS unchanged.
REQ-040 stall=1 for 3 cycles with branch_taken then trap on 3rd -> pc held, then 0x80; reset during stall -> 0x0 next cycle.
REQ-041 WIDTH=8, pc=0xFC, free run -> pc_out 0x00 next cycle, no flags.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC source select
// and the sequential step size.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_TRAP,
        SEL_HOLD,
        SEL_RET,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_SEQ
    } pc_sel_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. The pointer marks the next write slot, so
// a push while full lands on the oldest entry and the count saturates.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;

    assign top   = mem[ptr - PW'(1)];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Pointer and occupancy; push and pop are never requested together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage is left uninitialised across reset; count gates its use.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with trap/stall/return/jump/branch redirection, a return
// address stack for call/return, and misaligned-target diversion to the trap
// vector.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             trap,
    input  logic             ret,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             redirect,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full
);
    pc_sel_t          sel;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] ras_top;
    logic             bad_target;
    logic             ras_push;
    logic             ras_pop;

    assign pc_plus4 = pc_out + WIDTH'(PC_STEP);

    // Next-PC source by priority; a return with nothing stacked falls through
    // to the sequential path and also suppresses any concurrent jump.
    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        if (reset)
            sel = SEL_RESET;
        else if (trap)
            sel = SEL_TRAP;
        else if (stall)
            sel = SEL_HOLD;
        else if (ret) begin
            if (!ras_empty)
                sel = SEL_RET;
        end else if (jump)
            sel = SEL_JUMP;
        else if (branch_taken)
            sel = SEL_BRANCH;

        case (sel)
            SEL_RET:    target = ras_top;
            SEL_JUMP:   target = jump_target;
            SEL_BRANCH: target = branch_target;
            default:    target = pc_plus4;
        endcase
    end

    assign bad_target = (sel == SEL_RET || sel == SEL_JUMP || sel == SEL_BRANCH)
                        && (target[1:0] != 2'b00);
    assign ras_push   = (sel == SEL_JUMP) && call && !bad_target;
    assign ras_pop    = (sel == SEL_RET) && !bad_target;

    // PC register and the one-cycle redirect/misaligned status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out     <= RESET_VECTOR;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (sel)
                SEL_TRAP: begin
                    pc_out     <= TRAP_VECTOR;
                    redirect   <= 1'b1;
                    misaligned <= 1'b0;
                end
                SEL_HOLD: begin
                    redirect   <= 1'b0;
                    misaligned <= 1'b0;
                end
                SEL_RET, SEL_JUMP, SEL_BRANCH: begin
                    pc_out     <= bad_target ? TRAP_VECTOR : target;
                    redirect   <= 1'b1;
                    misaligned <= bad_target;
                end
                default: begin
                    pc_out     <= pc_plus4;
                    redirect   <= 1'b0;
                    misaligned <= 1'b0;
                end
            endcase
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit and an 8-bit instance driven by the same
// controls, each compared every cycle against a queue-based reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, trap, stall, ret, jump, call, branch;
    logic [31:0] jt, bt;

    logic [31:0] pc_a, p4_a;
    logic        red_a, mis_a, emp_a, full_a;
    logic [7:0]  pc_b, p4_b;
    logic        red_b, mis_b, emp_b, full_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc  [2];
    logic        m_red [2];
    logic        m_mis [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RAS_DEPTH(4)) u_dut32 (
        .clk(clk), .reset(rst), .stall(stall), .trap(trap), .ret(ret),
        .jump(jump), .call(call), .jump_target(jt), .branch_taken(branch),
        .branch_target(bt), .pc_out(pc_a), .pc_plus4(p4_a), .redirect(red_a),
        .misaligned(mis_a), .ras_empty(emp_a), .ras_full(full_a)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80), .RAS_DEPTH(4)) u_dut8 (
        .clk(clk), .reset(rst), .stall(stall), .trap(trap), .ret(ret),
        .jump(jump), .call(call), .jump_target(jt[7:0]), .branch_taken(branch),
        .branch_target(bt[7:0]), .pc_out(pc_b), .pc_plus4(p4_b), .redirect(red_b),
        .misaligned(mis_b), .ras_empty(emp_b), .ras_full(full_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] qtop(input int k);
        return (k == 0) ? q0[q0.size()-1] : q1[q1.size()-1];
    endfunction

    // Bounded stack: pushing onto a full stack forgets the oldest address.
    task automatic qpush(input int k, input logic [31:0] v);
        if (k == 0) begin
            if (q0.size() == 4) void'(q0.pop_front());
            q0.push_back(v);
        end else begin
            if (q1.size() == 4) void'(q1.pop_front());
            q1.push_back(v);
        end
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(q0.pop_back());
        else        void'(q1.pop_back());
    endtask

    task automatic model_step(input int k);
        logic [31:0] mask, seq, tgt;
        logic        go, do_push, do_pop;
        mask    = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        seq     = (m_pc[k] + 32'd4) & mask;
        go      = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        tgt     = seq;
        if (rst) begin
            m_pc[k] = 32'h0; m_red[k] = 1'b0; m_mis[k] = 1'b0;
            if (k == 0) q0.delete(); else q1.delete();
        end else if (trap) begin
            m_pc[k] = 32'h80; m_red[k] = 1'b1; m_mis[k] = 1'b0;
        end else if (stall) begin
            m_red[k] = 1'b0; m_mis[k] = 1'b0;
        end else begin
            if (ret) begin
                if (qsize(k) > 0) begin go = 1'b1; tgt = qtop(k); do_pop = 1'b1; end
            end else if (jump) begin
                go = 1'b1; tgt = jt & mask; do_push = call;
            end else if (branch) begin
                go = 1'b1; tgt = bt & mask;
            end
            if (!go) begin
                m_pc[k] = seq; m_red[k] = 1'b0; m_mis[k] = 1'b0;
            end else if (tgt[1:0] != 2'b00) begin
                m_pc[k] = 32'h80; m_red[k] = 1'b1; m_mis[k] = 1'b1;
            end else begin
                if (do_pop)  qpop(k);
                if (do_push) qpush(k, seq);
                m_pc[k] = tgt; m_red[k] = 1'b1; m_mis[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("pc32",    pc_a,            m_pc[0]);
        chk("plus4_32", p4_a,           m_pc[0] + 32'd4);
        chk("redir32", {31'b0, red_a},  {31'b0, m_red[0]});
        chk("mis32",   {31'b0, mis_a},  {31'b0, m_mis[0]});
        chk("empty32", {31'b0, emp_a},  {31'b0, qsize(0) == 0});
        chk("full32",  {31'b0, full_a}, {31'b0, qsize(0) == 4});
        chk("pc8",     {24'b0, pc_b},   m_pc[1]);
        chk("plus4_8", {24'b0, p4_b},   (m_pc[1] + 32'd4) & 32'hFF);
        chk("redir8",  {31'b0, red_b},  {31'b0, m_red[1]});
        chk("mis8",    {31'b0, mis_b},  {31'b0, m_mis[1]});
        chk("empty8",  {31'b0, emp_b},  {31'b0, qsize(1) == 0});
        chk("full8",   {31'b0, full_b}, {31'b0, qsize(1) == 4});
    endtask

    task automatic cyc(input logic r, input logic t, input logic s, input logic rt,
                       input logic j, input logic c, input logic b,
                       input logic [31:0] jtv, input logic [31:0] btv);
        rst = r; trap = t; stall = s; ret = rt; jump = j; call = c; branch = b;
        jt = jtv; bt = btv;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] v;
        v = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) v[1:0] = 2'($urandom_range(1, 3));
        return v;
    endfunction

    initial begin
        rst = 1'b1; trap = 1'b0; stall = 1'b0; ret = 1'b0; jump = 1'b0;
        call = 1'b0; branch = 1'b0; jt = '0; bt = '0;
        m_pc[0] = '0; m_pc[1] = '0; m_red[0] = 0; m_red[1] = 0; m_mis[0] = 0; m_mis[1] = 0;
        @(negedge clk);

        // reset then free run
        cyc(1,0,0,0,0,0,0, 0, 0);
        chk("rst_pc", pc_a, 32'h0);
        repeat (3) cyc(0,0,0,0,0,0,0, 0, 0);
        chk("seq_pc", pc_a, 32'hC);
        cyc(0,0,0,0,0,0,0, 0, 0);

        // call then return
        cyc(0,0,0,0,1,1,0, 32'h100, 0);
        chk("call_pc", pc_a, 32'h100);
        cyc(0,0,0,1,0,0,0, 0, 0);
        chk("ret_pc", pc_a, 32'h14);
        chk("ret_empty", {31'b0, emp_a}, 32'h1);

        // overflow the stack with five calls, then unwind
        cyc(1,0,0,0,0,0,0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0,0,0,0,1,1,0, 32'(i) * 32'h100, 0);
            if (i == 4) chk("ras_full4", {31'b0, full_a}, 32'h1);
        end
        cyc(0,0,0,1,0,0,0, 0, 0); chk("pop1", pc_a, 32'h404);
        cyc(0,0,0,1,0,0,0, 0, 0); chk("pop2", pc_a, 32'h304);
        cyc(0,0,0,1,0,0,0, 0, 0); chk("pop3", pc_a, 32'h204);
        cyc(0,0,0,1,0,0,0, 0, 0); chk("pop4", pc_a, 32'h104);
        cyc(0,0,0,1,0,0,0, 0, 0); chk("pop_empty", pc_a, 32'h108);

        // misaligned branch
        cyc(0,0,0,0,0,0,1, 0, 32'h202);
        chk("mis_pc", pc_a, 32'h80);
        cyc(0,0,0,0,0,0,0, 0, 0);

        // stall with branch, trap on third cycle, reset during stall
        cyc(0,0,1,0,0,0,1, 0, 32'h300);
        cyc(0,0,1,0,0,0,1, 0, 32'h300);
        chk("stall_pc", pc_a, 32'h84);
        cyc(0,1,1,0,0,0,1, 0, 32'h300);
        chk("trap_pc", pc_a, 32'h80);
        cyc(0,0,1,0,0,0,0, 0, 0);
        cyc(1,0,1,0,0,0,0, 0, 0);
        chk("stall_rst", pc_a, 32'h0);

        // 8-bit wrap
        cyc(0,0,0,0,1,0,0, 32'hFC, 0);
        cyc(0,0,0,0,0,0,0, 0, 0);
        chk("wrap8", {24'b0, pc_b}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0,  $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0,  $urandom_range(0, 1) == 0,
                $urandom_range(0, 3) == 0,  rnd_target(), rnd_target());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
